// File: rtl/csr_unit.sv
// Machine-mode CSR file and trap controller (mstatus/mie/mtvec/mscratch/mepc/mcause/mip/mcycle).
// Latency: CSR reads, epc_taken and epc are combinational; state updates at the next rising edge.
// Backpressure: none. valid=0 freezes architectural state except mcycle and the irq synchronisers.
//
// Ports:
//   clk, rst_n               core clock, synchronous active-low reset
//   inst, valid, pc, wdata   instruction in stage, live flag, its PC, rs1 operand
//   csr_we, csr_re, is_mret  decoder controls
//   ext_irq, timer_irq       asynchronous interrupt levels
//   rdata                    old CSR value (0 unless csr_re)
//   epc_taken, epc           fetch redirect for interrupt entry / MRET
module csr_unit #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] inst,
  input  logic          valid,
  input  logic          csr_we,
  input  logic          csr_re,
  input  logic          is_mret,
  input  logic [DW-1:0] pc,
  input  logic [DW-1:0] wdata,
  input  logic          ext_irq,
  input  logic          timer_irq,
  output logic [DW-1:0] rdata,
  output logic          epc_taken,
  output logic [DW-1:0] epc
);

  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MIE      = 12'h304;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MIP      = 12'h344;
  localparam logic [11:0] A_MCYCLE   = 12'hB00;

  logic          mst_mie_q, mst_mie_d, mst_mpie_q, mst_mpie_d;
  logic          mie_mtie_q, mie_mtie_d, mie_meie_q, mie_meie_d;
  logic [DW-1:0] mtvec_q, mtvec_d, mscratch_q, mscratch_d;
  logic [DW-1:0] mepc_q, mepc_d, mcause_q, mcause_d, mcycle_q, mcycle_d;
  logic          ext_s1_q, ext_s1_d, ext_s2_q, ext_s2_d;
  logic          tmr_s1_q, tmr_s1_d, tmr_s2_q, tmr_s2_d;

  logic [2:0]    funct3;
  logic [4:0]    uimm;
  logic [11:0]   addr;
  logic [DW-1:0] src, old_val, new_val;
  logic          op_valid, wr_suppress, csr_wr;
  logic          irq_ext, irq_tmr, irq_take, mret_take;
  logic [3:0]    code;
  logic          unused_inst;

  assign unused_inst = ^{inst[11:0], pc[1:0]};

  always_comb begin
    funct3      = inst[14:12];
    uimm        = inst[19:15];
    addr        = inst[31:20];
    // funct3[1:0]==0 is not a CSR op (ECALL/MRET space or reserved)
    op_valid    = (funct3[1:0] != 2'b00);
    src         = funct3[2] ? {{(DW-5){1'b0}}, uimm} : wdata;
    // RS/RC with a zero rs1/uimm field is a pure read
    wr_suppress = funct3[1] && (uimm == 5'd0);

    old_val = '0;
    unique case (addr)
      A_MSTATUS:  old_val = {{(DW-8){1'b0}}, mst_mpie_q, 3'b000, mst_mie_q, 3'b000};
      A_MIE:      old_val = {{(DW-12){1'b0}}, mie_meie_q, 3'b000, mie_mtie_q, 7'b0};
      A_MTVEC:    old_val = mtvec_q;
      A_MSCRATCH: old_val = mscratch_q;
      A_MEPC:     old_val = mepc_q;
      A_MCAUSE:   old_val = mcause_q;
      A_MIP:      old_val = {{(DW-12){1'b0}}, ext_s2_q, 3'b000, tmr_s2_q, 7'b0};
      A_MCYCLE:   old_val = mcycle_q;
      default:    old_val = '0;
    endcase

    unique case (funct3[1:0])
      2'b01:   new_val = src;
      2'b10:   new_val = old_val | src;
      2'b11:   new_val = old_val & ~src;
      default: new_val = old_val;
    endcase

    rdata = csr_re ? old_val : '0;

    irq_ext   = mst_mie_q & mie_meie_q & ext_s2_q;
    irq_tmr   = mst_mie_q & mie_mtie_q & tmr_s2_q;
    irq_take  = rst_n & valid & (irq_ext | irq_tmr);
    mret_take = rst_n & valid & is_mret & ~irq_take;
    epc_taken = irq_take | mret_take;
    code      = irq_ext ? 4'd11 : 4'd7;

    epc = '0;
    if (irq_take) begin
      epc = {mtvec_q[DW-1:2], 2'b00};
      if (mtvec_q[1:0] == 2'b01) epc = epc + {{(DW-6){1'b0}}, code, 2'b00};
    end else if (mret_take) begin
      epc = mepc_q;
    end

    // A redirect kills the instruction, including its CSR write
    csr_wr = valid & csr_we & ~epc_taken & op_valid & ~wr_suppress;

    mst_mie_d  = mst_mie_q;
    mst_mpie_d = mst_mpie_q;
    mie_mtie_d = mie_mtie_q;
    mie_meie_d = mie_meie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mcycle_d   = mcycle_q + 1'b1;
    ext_s1_d   = ext_irq;
    ext_s2_d   = ext_s1_q;
    tmr_s1_d   = timer_irq;
    tmr_s2_d   = tmr_s1_q;

    if (csr_wr) begin
      unique case (addr)
        A_MSTATUS: begin
          mst_mie_d  = new_val[3];
          mst_mpie_d = new_val[7];
        end
        A_MIE: begin
          mie_mtie_d = new_val[7];
          mie_meie_d = new_val[11];
        end
        // only direct (0) and vectored (1) modes are retained
        A_MTVEC:    mtvec_d    = {new_val[DW-1:2], 1'b0, (new_val[1:0] == 2'b01)};
        A_MSCRATCH: mscratch_d = new_val;
        A_MEPC:     mepc_d     = {new_val[DW-1:2], 2'b00};
        A_MCAUSE:   mcause_d   = new_val;
        A_MCYCLE:   mcycle_d   = new_val;
        default: ;
      endcase
    end

    if (irq_take) begin
      mepc_d     = {pc[DW-1:2], 2'b00};
      mcause_d   = {1'b1, {(DW-5){1'b0}}, code};
      mst_mpie_d = mst_mie_q;
      mst_mie_d  = 1'b0;
    end else if (mret_take) begin
      mst_mie_d  = mst_mpie_q;
      mst_mpie_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mst_mie_q  <= 1'b0;
      mst_mpie_q <= 1'b0;
      mie_mtie_q <= 1'b0;
      mie_meie_q <= 1'b0;
      mtvec_q    <= '0;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mcycle_q   <= '0;
      ext_s1_q   <= 1'b0;
      ext_s2_q   <= 1'b0;
      tmr_s1_q   <= 1'b0;
      tmr_s2_q   <= 1'b0;
    end else begin
      mst_mie_q  <= mst_mie_d;
      mst_mpie_q <= mst_mpie_d;
      mie_mtie_q <= mie_mtie_d;
      mie_meie_q <= mie_meie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mcycle_q   <= mcycle_d;
      ext_s1_q   <= ext_s1_d;
      ext_s2_q   <= ext_s2_d;
      tmr_s1_q   <= tmr_s1_d;
      tmr_s2_q   <= tmr_s2_d;
    end
  end

endmodule

// File: tb/tb_csr_unit.sv
// Directed bench for csr_unit: table of single-cycle CSR accesses plus
// hand-written interrupt, MRET, mcycle-wrap and reset sequences.
module tb_csr_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] inst, pc, wdata, rdata, epc;
  logic        valid, csr_we, csr_re, is_mret, ext_irq, timer_irq, epc_taken;

  int n_cmp = 0;
  int n_bad = 0;

  csr_unit #(.DW(32)) dut (
    .clk(clk), .rst_n(rst_n), .inst(inst), .valid(valid), .csr_we(csr_we),
    .csr_re(csr_re), .is_mret(is_mret), .pc(pc), .wdata(wdata),
    .ext_irq(ext_irq), .timer_irq(timer_irq), .rdata(rdata),
    .epc_taken(epc_taken), .epc(epc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] addr;
    logic [2:0]  f3;
    logic [4:0]  rs;
    logic [31:0] wd;
    logic        we;
    logic        re;
    logic        vld;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[23];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [11:0] a, input logic [2:0] f3, input logic [4:0] rs,
                       input logic [31:0] wd, input logic we, input logic re);
    inst   = {a, rs, f3, 5'd1, 7'h73};
    wdata  = wd;
    csr_we = we;
    csr_re = re;
  endtask

  task automatic idle();
    drive(12'h000, 3'b000, 5'd0, 32'h0, 1'b0, 1'b0);
  endtask

  // Inputs already set: sample at negedge, then advance to just after the next posedge.
  task automatic to_neg();
    @(negedge clk);
  endtask
  task automatic to_next();
    @(posedge clk);
    #1;
  endtask

  // One cycle: read addr (no write) and compare rdata, plus epc_taken.
  task automatic read_chk(input string name, input logic [11:0] a, input logic [31:0] exp);
    drive(a, 3'b010, 5'd0, 32'h0, 1'b0, 1'b1);
    to_neg();
    chk(name, rdata, exp);
    chk({name, "_nojump"}, {31'b0, epc_taken}, 32'h0);
    to_next();
  endtask

  initial begin
    //            addr     f3      rs     wdata         we    re    vld   exp_rdata
    vecs[0]  = '{12'h340, 3'b001, 5'd1,  32'hDEADBEEF, 1'b1, 1'b1, 1'b1, 32'h0};
    vecs[1]  = '{12'h340, 3'b010, 5'd5,  32'h0000000F, 1'b1, 1'b1, 1'b1, 32'hDEADBEEF};
    vecs[2]  = '{12'h340, 3'b111, 5'h0F, 32'h0,        1'b1, 1'b1, 1'b1, 32'hDEADBEEF};
    vecs[3]  = '{12'h340, 3'b010, 5'd0,  32'hFFFFFFFF, 1'b1, 1'b1, 1'b1, 32'hDEADBEE0};
    vecs[4]  = '{12'h341, 3'b001, 5'd1,  32'h00001003, 1'b1, 1'b1, 1'b1, 32'h0};
    vecs[5]  = '{12'h341, 3'b010, 5'd0,  32'h0,        1'b0, 1'b1, 1'b1, 32'h00001000};
    vecs[6]  = '{12'h344, 3'b001, 5'd1,  32'hFFFFFFFF, 1'b1, 1'b1, 1'b1, 32'h0};
    vecs[7]  = '{12'h344, 3'b010, 5'd0,  32'h0,        1'b0, 1'b1, 1'b1, 32'h0};
    vecs[8]  = '{12'h7C0, 3'b001, 5'd1,  32'h00001234, 1'b1, 1'b1, 1'b1, 32'h0};
    vecs[9]  = '{12'h7C0, 3'b010, 5'd0,  32'h0,        1'b0, 1'b1, 1'b1, 32'h0};
    vecs[10] = '{12'h305, 3'b001, 5'd1,  32'h00000103, 1'b1, 1'b1, 1'b1, 32'h0};
    vecs[11] = '{12'h305, 3'b010, 5'd0,  32'h0,        1'b0, 1'b1, 1'b1, 32'h00000100};
    vecs[12] = '{12'h300, 3'b001, 5'd1,  32'hFFFFFFFF, 1'b1, 1'b1, 1'b1, 32'h0};
    vecs[13] = '{12'h300, 3'b001, 5'd1,  32'h0,        1'b1, 1'b1, 1'b1, 32'h00000088};
    vecs[14] = '{12'h300, 3'b010, 5'd0,  32'h0,        1'b0, 1'b1, 1'b1, 32'h0};
    vecs[15] = '{12'h340, 3'b001, 5'd1,  32'h0,        1'b1, 1'b1, 1'b0, 32'hDEADBEE0};
    vecs[16] = '{12'h340, 3'b010, 5'd0,  32'h0,        1'b0, 1'b0, 1'b1, 32'h0};
    vecs[17] = '{12'h340, 3'b110, 5'h10, 32'h0,        1'b1, 1'b1, 1'b1, 32'hDEADBEE0};
    vecs[18] = '{12'h340, 3'b010, 5'd0,  32'h0,        1'b0, 1'b1, 1'b1, 32'hDEADBEF0};
    vecs[19] = '{12'h342, 3'b001, 5'd1,  32'h00000005, 1'b1, 1'b1, 1'b1, 32'h0};
    vecs[20] = '{12'h342, 3'b001, 5'd1,  32'h0,        1'b1, 1'b1, 1'b1, 32'h00000005};
    vecs[21] = '{12'h340, 3'b101, 5'h1F, 32'h0,        1'b1, 1'b1, 1'b1, 32'hDEADBEF0};
    vecs[22] = '{12'h340, 3'b010, 5'd0,  32'h0,        1'b0, 1'b1, 1'b1, 32'h0000001F};

    rst_n = 1'b0; valid = 1'b0; is_mret = 1'b0; pc = 32'h0;
    ext_irq = 1'b0; timer_irq = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_epc_taken", {31'b0, epc_taken}, 32'h0);
    chk("reset_epc", epc, 32'h0);
    to_next();
    rst_n = 1'b1;
    valid = 1'b1;

    // ---- table-driven CSR accesses ----
    for (int i = 0; i < 23; i++) begin
      drive(vecs[i].addr, vecs[i].f3, vecs[i].rs, vecs[i].wd, vecs[i].we, vecs[i].re);
      valid = vecs[i].vld;
      to_neg();
      chk($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_epc_taken", i), {31'b0, epc_taken}, 32'h0);
      to_next();
    end
    valid = 1'b1;

    // ---- direct-mode external interrupt (mtvec already 0x100) ----
    drive(12'h304, 3'b001, 5'd1, 32'h00000800, 1'b1, 1'b0); to_next();
    drive(12'h300, 3'b001, 5'd1, 32'h00000008, 1'b1, 1'b0); to_next();
    idle();
    pc = 32'h200;
    ext_irq = 1'b1;
    to_neg(); chk("irq_lat0", {31'b0, epc_taken}, 32'h0); to_next();
    to_neg(); chk("irq_lat1", {31'b0, epc_taken}, 32'h0); to_next();
    to_neg();
    chk("irq_taken", {31'b0, epc_taken}, 32'h1);
    chk("irq_epc_direct", epc, 32'h100);
    to_next();
    read_chk("trap_mepc", 12'h341, 32'h200);
    read_chk("trap_mcause", 12'h342, 32'h8000000B);
    read_chk("trap_mstatus", 12'h300, 32'h80);
    read_chk("trap_mip", 12'h344, 32'h800);
    ext_irq = 1'b0;

    // ---- vectored mode, both pending, then MRET ----
    drive(12'h305, 3'b001, 5'd1, 32'h00000101, 1'b1, 1'b0); to_next();
    drive(12'h304, 3'b001, 5'd1, 32'h00000880, 1'b1, 1'b0); to_next();
    idle();
    ext_irq = 1'b1; timer_irq = 1'b1;
    repeat (3) begin
      to_neg(); chk("mie_off_no_trap", {31'b0, epc_taken}, 32'h0); to_next();
    end
    drive(12'h300, 3'b010, 5'd1, 32'h00000008, 1'b1, 1'b1);
    to_neg(); chk("set_mie_rdata", rdata, 32'h80); to_next();
    idle();
    pc = 32'h300;
    to_neg();
    chk("vec_taken", {31'b0, epc_taken}, 32'h1);
    chk("vec_epc_ext_wins", epc, 32'h12C);
    to_next();
    is_mret = 1'b1;
    to_neg();
    chk("mret_taken", {31'b0, epc_taken}, 32'h1);
    chk("mret_epc", epc, 32'h300);
    to_next();
    // MIE is back on, so the still-pending irq beats MRET and the CSR write
    drive(12'h300, 3'b001, 5'd1, 32'h0, 1'b1, 1'b1);
    pc = 32'h400;
    to_neg();
    chk("mret_mstatus", rdata, 32'h88);
    chk("prio_taken", {31'b0, epc_taken}, 32'h1);
    chk("prio_epc", epc, 32'h12C);
    to_next();
    is_mret = 1'b0;
    read_chk("prio_mepc", 12'h341, 32'h400);
    read_chk("prio_mstatus", 12'h300, 32'h80);
    read_chk("prio_mcause", 12'h342, 32'h8000000B);
    ext_irq = 1'b0; timer_irq = 1'b0;

    // ---- mcycle wrap ----
    drive(12'hB00, 3'b001, 5'd1, 32'hFFFFFFFE, 1'b1, 1'b0); to_next();
    read_chk("mcycle0", 12'hB00, 32'hFFFFFFFE);
    read_chk("mcycle1", 12'hB00, 32'hFFFFFFFF);
    read_chk("mcycle2", 12'hB00, 32'h0);

    // ---- reset in the middle of a trap ----
    idle();
    repeat (3) to_next();
    ext_irq = 1'b1;
    repeat (2) to_next();
    drive(12'h300, 3'b110, 5'd8, 32'h0, 1'b1, 1'b1);
    to_neg(); chk("rst_setup_mstatus", rdata, 32'h80); to_next();
    idle();
    to_neg();
    chk("rst_pre_taken", {31'b0, epc_taken}, 32'h1);
    #1;
    rst_n = 1'b0;
    ext_irq = 1'b0;
    #1;
    chk("rst_taken", {31'b0, epc_taken}, 32'h0);
    chk("rst_epc", epc, 32'h0);
    to_next();
    rst_n = 1'b1;
    read_chk("post_mcycle", 12'hB00, 32'h0);
    read_chk("post_mstatus", 12'h300, 32'h0);
    read_chk("post_mie", 12'h304, 32'h0);
    read_chk("post_mtvec", 12'h305, 32'h0);
    read_chk("post_mscratch", 12'h340, 32'h0);
    read_chk("post_mepc", 12'h341, 32'h0);
    read_chk("post_mcause", 12'h342, 32'h0);
    read_chk("post_mip", 12'h344, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
